// File: rtl/memory_responder_if.sv
// Bus between the CPU-side MAR/MDR logic and the memory responder.
// The master issues Read/Write with Address/DataIn; the responder returns
// read data on MDataIn together with Done/Busy/Error status.
interface memory_responder_if #(
    parameter int ADDR_BITS = 9
);
    logic                 Read;
    logic                 Write;
    logic [ADDR_BITS-1:0] Address;
    logic [31:0]          DataIn;
    logic [31:0]          MDataIn;
    logic                 Done;
    logic                 Busy;
    logic                 Error;

    modport master (
        output Read, Write, Address, DataIn,
        input  MDataIn, Done, Busy, Error
    );

    modport slave (
        input  Read, Write, Address, DataIn,
        output MDataIn, Done, Busy, Error
    );
endinterface

// File: rtl/memory_responder.sv
// Single-port word memory with a fixed-latency handshake.
// A request is captured in IDLE, held for WAIT_CYCLES extra cycles, executed
// on the edge that leaves WAIT, and acknowledged by a one-cycle Done in DONE.
// All status outputs come straight from flops so the requester never sees a
// combinational path from its own request lines.
module memory_responder #(
    parameter int ADDR_BITS   = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                clr,
    memory_responder_if.slave   bus
);
    localparam int         DEPTH   = 1 << ADDR_BITS;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               st, nxt;
    logic [3:0]           cnt;
    logic [ADDR_BITS-1:0] cap_addr;
    logic [31:0]          cap_data;
    logic                 cap_wr;
    logic [31:0]          mdata;
    logic                 done_q, busy_q, err_q;
    logic                 accept, collide, exec;
    logic [31:0]          mem [DEPTH];

    // Next-state decode; requests are only looked at in IDLE.
    always_comb begin
        nxt     = st;
        accept  = 1'b0;
        collide = 1'b0;
        case (st)
            S_IDLE: begin
                if (bus.Read ^ bus.Write) begin
                    nxt    = S_WAIT;
                    accept = 1'b1;
                end else if (bus.Read && bus.Write) begin
                    collide = 1'b1;
                end
            end
            S_WAIT:  if (cnt == 4'd0) nxt = S_DONE;
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // The captured operation fires on the edge that leaves WAIT.
    assign exec = (st == S_WAIT) && (cnt == 4'd0);

    // State, capture registers, read data and registered status flags.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            st       <= S_IDLE;
            cnt      <= 4'd0;
            cap_addr <= '0;
            cap_data <= 32'h0;
            cap_wr   <= 1'b0;
            mdata    <= 32'h0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            st     <= nxt;
            done_q <= (nxt == S_DONE);
            busy_q <= (nxt != S_IDLE);
            if (collide) err_q <= 1'b1;
            if (accept) begin
                cap_addr <= bus.Address;
                cap_data <= bus.DataIn;
                cap_wr   <= bus.Write;
                cnt      <= WAIT_LD;
            end else if (st == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (exec && !cap_wr) mdata <= mem[cap_addr];
        end
    end

    // Storage is deliberately not reset; a reset mid-access drops st to IDLE
    // asynchronously, so exec is already low at the next edge.
    always_ff @(posedge clk) begin
        if (exec && cap_wr) mem[cap_addr] <= cap_data;
    end

    assign bus.MDataIn = mdata;
    assign bus.Done    = done_q;
    assign bus.Busy    = busy_q;
    assign bus.Error   = err_q;
endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001: Parameter ADDR_BITS, default 9, SHALL set the word-address width; storage depth SHALL be 2^ADDR_BITS 32-bit words.
REQ-002: Parameter WAIT_CYCLES, default 2, range 0..15, SHALL set the extra wait cycles inserted before each access completes.
REQ-003: clk  input  1  SHALL be the sole clock; all state SHALL change on its rising edge only.
REQ-004: clr  input  1  SHALL be the asynchronous, active-low reset.
REQ-005: Read  input  1  SHALL request a memory read, sampled only in IDLE.
REQ-006: Write  input  1  SHALL request a memory write, sampled only in IDLE.
REQ-007: Address  input  ADDR_BITS  SHALL be the word address from the MAR.
REQ-008: DataIn  input  32  SHALL be the write data from the MDR output.
REQ-009: MDataIn  output  32  SHALL carry read data toward the MDR memory-side input.
REQ-010: Done  output  1  SHALL pulse high for exactly one cycle when an access completes.
REQ-011: Busy  output  1  SHALL be high whenever state is not IDLE.
REQ-012: Error  output  1  SHALL be a sticky flag set when Read and Write are sampled high together in IDLE.

Function
REQ-013: The FSM SHALL have exactly three states: IDLE, WAIT, DONE.
REQ-014: In IDLE, Read XOR Write high at a rising edge SHALL accept the request.
- Address, DataIn and the operation type are captured.
- The wait counter loads WAIT_CYCLES.
- State moves to WAIT.
REQ-015: In IDLE, Read and Write both high SHALL leave state in IDLE, set Error, and leave memory and MDataIn unchanged.
REQ-016: In WAIT, at each rising edge with counter non-zero, the counter SHALL decrement.
REQ-017: In WAIT, at the rising edge with counter zero, the captured operation SHALL execute and state SHALL move to DONE.
- Read: MDataIn is loaded with mem[captured address].
- Write: mem[captured address] is loaded with captured DataIn.
REQ-018: In DONE, Done SHALL be 1; state SHALL return to IDLE on the next edge, and Read/Write SHALL be ignored.
REQ-019: Latency SHALL be WAIT_CYCLES+2 rising edges from the accepting edge to the edge at which Done falls; Done is high for the cycle after the executing edge (WAIT_CYCLES=2: accept at edge 0, execute at edge 3, Done high between edges 3 and 4).
REQ-020: Read/Write/Address/DataIn changes while Busy=1 SHALL have no effect on the access in flight.
REQ-021: MDataIn SHALL hold the most recent completed read value; writes and errors SHALL leave it unchanged.
REQ-022: A read of an address written by the immediately preceding write SHALL return the new data.
REQ-023: Back-to-back accesses SHALL be possible: a request asserted during DONE is ignored, but one held high into the following IDLE cycle is accepted.
REQ-024: Done, Busy and Error SHALL be driven directly from registers, with no combinational path from inputs.

Reset
REQ-025: clr=0 SHALL immediately force the following, regardless of clk:
- state=IDLE, counter=0
- MDataIn=32'h0, Done=0, Busy=0, Error=0
REQ-026: Error SHALL clear only on reset.
REQ-027: Memory array contents SHALL NOT be cleared by reset.
REQ-028: Reset asserted in WAIT SHALL abort the access: no memory write occurs and MDataIn remains 0.
REQ-029: After clr rises, the first rising edge SHALL be able to accept a request.

Verification
REQ-030: Write 32'hDEADBEEF to address 9'h005, then read 9'h005 -> Done pulses for each access, exactly 4 edges after acceptance (WAIT_CYCLES=2), and the read returns MDataIn=32'hDEADBEEF.
REQ-031: Read and Write both high in IDLE -> Error=1 and stays 1, Busy stays 0, MDataIn unchanged; a later valid read still completes normally.
REQ-032: Write 32'h1 to address 9'h010, then toggle Address, DataIn and Write during WAIT -> only mem[9'h010]=32'h1 changes, and Done pulses once.
REQ-033: Pulse clr low during WAIT of a write of 32'hCAFE to 9'h020 -> all outputs are 0 immediately; a subsequent read of 9'h020 returns its pre-reset contents.
REQ-034: With WAIT_CYCLES=0, hold Read high on address 9'h1FF -> accept, execute, then Done in the next cycle; a second read is accepted in the IDLE cycle after DONE, giving a 3-cycle repeat period.
REQ-035: Hold Read high continuously for 10 cycles -> Done pulses at a fixed period of WAIT_CYCLES+3 cycles, and Busy never glitches low mid-access.
